rgb_pwm_seq: RTL and testbench
==============================

// Module: rgb_pwm_seq
// PURPOSE
//  Parametrised successor to the on/off RGB blinker: N-channel PWM LED driver with a programmable step sequencer.
//  Plays a DEPTH-entry pattern table (per-channel duty + dwell), stepping on an external tick strobe (tick_100ms).
//  Three modes: hold, step and fade. Sits between the timebase/tick generator and the physical rgb_led drive stage.
// PARAMETERS
//  NCH    3  number of LED channels
//  PWM_W  8  duty/PWM counter width; period = 2**PWM_W clk cycles
//  DEPTH  8  pattern table entries (power of 2, >=2); AW = $clog2(DEPTH)
//  DUR_W  4  dwell field width, in tick_in strobes
// PORTS
//  clk      in   1             system clock
//  rst      in   1             synchronous, active-high reset
//  tick_in  in   1             one-cycle step-timebase strobe
//  en       in   1             1 = run sequencer, 0 = idle (LEDs dark)
//  mode     in   2             00 hold, 01 step, 10 fade, 11 = step
//  len      in   AW            index of last active step
//  wr_en    in   1             pattern table write strobe
//  wr_addr  in   AW            table write address
//  wr_data  in   NCH*PWM_W+DUR_W  {dur, duty[NCH-1]..duty[0]}, duty[0] in LSBs of the duty field
//  led      out  NCH           PWM outputs, active high
//  step_idx out  AW            index of the step currently shown
//  busy     out  1             1 while not in IDLE
// BEHAVIOUR
//  Reset: led=0, step_idx=0, busy=0, state=IDLE, pwm_cnt=0, duty regs=0, dwell=0; table contents are NOT reset.
//  PWM: free-running pwm_cnt, wraps 2**PWM_W-1 -> 0.
//    led[i] registered = (pwm_cnt < duty[i]), 1-cycle latency. duty 0 = always off; max duty = on 2**PWM_W-1 of 2**PWM_W.
//  Table: synchronous write, registered read. Write and LOAD to the same address in one cycle: LOAD gets OLD data.
//  FSM states:
//    IDLE: duty=0, step_idx=0, busy=0. en=1 -> LOAD with idx 0.
//    LOAD (1 cycle): fetch entry[idx], dwell = max(dur,1).
//      step/hold: duty <= entry duty.
//      fade: target <= entry duty; current duty is kept.
//      tick_in is ignored while in LOAD. Next state is RUN.
//    RUN:
//      Each tick_in decrements dwell. When a tick arrives with dwell==1:
//        hold: stay at the same step and reload it.
//        step/fade: idx = (idx>=last) ? 0 : idx+1, then -> LOAD.
//      last = min(len, DEPTH-1), sampled at the advance.
//  Fade: each pwm_cnt wrap in RUN moves every duty[i] by 1 toward target[i]; duty stops at the target, no overshoot.
//  en=0 in any state -> IDLE next cycle; led all 0 within 2 cycles; re-enable restarts at step 0.
//  mode is sampled only in LOAD; a mid-step change takes effect at the next LOAD.
//  rst overrides all inputs, including a simultaneous en/wr_en/tick_in.
// STRUCTURE
//  Shared package rgb_seq_pkg holds:
//    state enum {IDLE, LOAD, RUN}
//    mode constants MODE_HOLD/MODE_STEP/MODE_FADE
//    field-slice helper for wr_data
//  Sub-module pwm_bank (#NCH, PWM_W): shared counter + NCH registered comparators; exports the wrap strobe.
//  Table as inferred RAM (iCE40 BRAM or distributed); sequencer FSM and fade logic stay in rgb_pwm_seq.
// TESTING (NCH=3, PWM_W=4, DEPTH=4, DUR_W=4)
//  1 Reset: rst held 3 cycles with en=1 -> led=000, busy=0, step_idx=0; the cycle after release, busy is still 0.
//  2 PWM duty: entry0 duty {15,8,0} dur=1, mode=step, len=0, en=1
//      -> per 16-cycle period, led[0] high 15, led[1] high 8, led[2] never.
//  3 Step wrap: entries 0..3 dur {1,2,1,3}, len=2, 10 ticks
//      -> step_idx sequence 0,1,1,2,0,1,1,2,0,1; entry 3 never shown.
//      Dur=0 entry dwells exactly 1 tick.
//  4 Fade: entry0 duty0=0, entry1 duty0=4, mode=fade
//      -> after LOAD of entry1, duty0 reaches 4 after exactly 4 PWM wraps, then holds.
//  5 Hold + same-address write: mode=hold on step 0; write entry0 duty0=12 in the LOAD cycle
//      -> old duty shown; new duty appears after the next reload.
//  6 en dropped mid-RUN at step 2 -> busy=0 next cycle, led=000 within 2 cycles; en re-raised -> step_idx=0.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// Shared types for the RGB PWM sequencer: FSM states,
// mode codes and the wr_data field-offset helper.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_FADE = 2'b10;

  // LSB of channel ch's duty field inside a table word.
  function automatic int duty_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/pwm_bank.sv
// Shared free-running PWM counter with NCH registered comparators.
// Ports: clk, rst, duty (packed per channel), led, wrap (cnt at max).
module pwm_bank
  import rgb_seq_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int PWM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*PWM_W-1:0] duty,
  output logic [NCH-1:0]     led,
  output logic               wrap
);

  logic [PWM_W-1:0] cnt;

  // High on the cycle whose edge takes cnt back to 0.
  assign wrap = &cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      led <= '0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      for (int i = 0; i < NCH; i++) begin
        led[i] <= cnt < duty[duty_lsb(i, PWM_W) +: PWM_W];
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_seq.sv
// N-channel PWM LED driver with a table-driven hold/step/fade sequencer.
// Ports: clk, rst, tick_in, en, mode, len, wr_en/wr_addr/wr_data, led, step_idx, busy.
module rgb_pwm_seq
  import rgb_seq_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int PWM_W = 8,
  parameter int DEPTH = 8,
  parameter int DUR_W = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int DTW  = NCH * PWM_W,
  localparam int DW   = DTW + DUR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_in,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [NCH-1:0] led,
  output logic [AW-1:0] step_idx,
  output logic          busy
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;

  state_t         state;
  state_t         nxt_state;
  logic [AW-1:0]  idx;
  logic [AW-1:0]  nxt_idx;
  logic [AW-1:0]  last;
  logic [DUR_W-1:0] dwell;
  logic [DUR_W-1:0] rd_dur;
  logic [DTW-1:0] duty;
  logic [DTW-1:0] target;
  logic [DTW-1:0] duty_fade;
  logic           hold_q;
  logic           wrap;

  // len is AW wide, so it can never exceed DEPTH-1.
  assign last     = len;
  assign rd_dur   = rd_q[DTW +: DUR_W];
  assign step_idx = idx;
  assign busy     = state != IDLE;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    unique case (state)
      IDLE: begin
        nxt_idx = '0;
        if (en) nxt_state = LOAD;
      end
      LOAD: nxt_state = RUN;
      RUN: begin
        if (tick_in && dwell == DUR_W'(1)) begin
          nxt_state = LOAD;
          if (!hold_q) begin
            nxt_idx = (idx >= last) ? '0 : idx + AW'(1);
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (!en) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
    end
  end

  // Read is addressed with the next index so the word is
  // already registered when LOAD consumes it; a write in the
  // LOAD cycle therefore cannot reach the fetched word.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
    rd_q <= mem[nxt_idx];
  end

  always_comb begin
    duty_fade = duty;
    for (int i = 0; i < NCH; i++) begin
      if (duty[duty_lsb(i, PWM_W) +: PWM_W] <
          target[duty_lsb(i, PWM_W) +: PWM_W]) begin
        duty_fade[duty_lsb(i, PWM_W) +: PWM_W] =
          duty[duty_lsb(i, PWM_W) +: PWM_W] + PWM_W'(1);
      end else if (duty[duty_lsb(i, PWM_W) +: PWM_W] >
                   target[duty_lsb(i, PWM_W) +: PWM_W]) begin
        duty_fade[duty_lsb(i, PWM_W) +: PWM_W] =
          duty[duty_lsb(i, PWM_W) +: PWM_W] - PWM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      dwell  <= '0;
      duty   <= '0;
      target <= '0;
      hold_q <= 1'b0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      if (nxt_state == IDLE) begin
        dwell  <= '0;
        duty   <= '0;
        target <= '0;
      end else begin
        unique case (state)
          LOAD: begin
            dwell  <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
            target <= rd_q[DTW-1:0];
            hold_q <= mode == MODE_HOLD;
            // Fade keeps the current duty and walks toward target.
            if (mode != MODE_FADE) duty <= rd_q[DTW-1:0];
          end
          RUN: begin
            if (tick_in) dwell <= dwell - DUR_W'(1);
            if (wrap) duty <= duty_fade;
          end
          default: ;
        endcase
      end
    end
  end

  pwm_bank #(
    .NCH   (NCH),
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk  (clk),
    .rst  (rst),
    .duty (duty),
    .led  (led),
    .wrap (wrap)
  );

endmodule

// File: tb/tb_rgb_pwm_seq.sv
// Self-checking bench for rgb_pwm_seq (NCH=3, PWM_W=4, DEPTH=4, DUR_W=4).
// Reference: table copy, per-period duty counts and a tick-level step model.
module tb_rgb_pwm_seq;

  localparam int NCH   = 3;
  localparam int PWM_W = 4;
  localparam int DEPTH = 4;
  localparam int DUR_W = 4;
  localparam int AW    = 2;
  localparam int DW    = NCH * PWM_W + DUR_W;
  localparam int PER   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_in;
  logic          en;
  logic [1:0]    mode;
  logic [AW-1:0] len;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NCH-1:0] led;
  logic [AW-1:0] step_idx;
  logic          busy;

  int ncmp = 0;
  int nfail = 0;
  int kcnt;
  int tbl_duty [DEPTH][NCH];
  int tbl_dur [DEPTH];
  int hi [NCH];

  rgb_pwm_seq #(
    .NCH   (NCH),
    .PWM_W (PWM_W),
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .en       (en),
    .mode     (mode),
    .len      (len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .led      (led),
    .step_idx (step_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release: equals the PWM phase modulo PER.
  always @(posedge clk) begin
    if (rst) kcnt <= 0;
    else kcnt <= kcnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int dur,
                    input int d0, input int d1, input int d2);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = {DUR_W'(dur), PWM_W'(d2), PWM_W'(d1), PWM_W'(d0)};
    tbl_dur[a]     = dur;
    tbl_duty[a][0] = d0;
    tbl_duty[a][1] = d1;
    tbl_duty[a][2] = d2;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    cyc(2);
  endtask

  task automatic restart();
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(3);
  endtask

  // One full PWM period whose samples all see the same duty.
  task automatic measure();
    int g;
    g = 0;
    while ((kcnt % PER) != 1 && g < 2 * PER) begin
      @(negedge clk);
      g++;
    end
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    for (int j = 0; j < PER; j++) begin
      for (int c = 0; c < NCH; c++) hi[c] += int'(led[c]);
      @(negedge clk);
    end
  endtask

  task automatic check_entry(input string tag, input int e);
    measure();
    for (int c = 0; c < NCH; c++) check(tag, hi[c], tbl_duty[e][c]);
  endtask

  task automatic run_steps(input int nticks);
    int midx;
    int rem;
    int lst;
    lst  = int'(len);
    midx = 0;
    rem  = (tbl_dur[0] == 0) ? 1 : tbl_dur[0];
    for (int t = 0; t < nticks; t++) begin
      check("step_idx", int'(step_idx), midx);
      tick();
      rem--;
      if (rem == 0) begin
        midx = (midx >= lst) ? 0 : midx + 1;
        rem  = (tbl_dur[midx] == 0) ? 1 : tbl_dur[midx];
      end
    end
  endtask

  task automatic run_fade(input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2);
    int a [NCH];
    int b [NCH];
    int nw;
    int d;
    int e;
    int g;
    a[0] = a0; a[1] = a1; a[2] = a2;
    b[0] = b0; b[1] = b1; b[2] = b2;
    mode = 2'b01;
    len  = 2'd1;
    wr(0, 1, a0, a1, a2);
    wr(1, 15, b0, b1, b2);
    restart();
    check_entry("fade_start", 0);
    mode = 2'b10;
    g = 0;
    while ((kcnt % PER) != 4 && g < 2 * PER) begin
      @(negedge clk);
      g++;
    end
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    nw = 1;
    for (int c = 0; c < NCH; c++) begin
      d = (b[c] > a[c]) ? b[c] - a[c] : a[c] - b[c];
      if (d + 1 > nw) nw = d + 1;
    end
    for (int j = 1; j <= nw; j++) begin
      measure();
      for (int c = 0; c < NCH; c++) begin
        if (b[c] >= a[c]) e = (a[c] + j > b[c]) ? b[c] : a[c] + j;
        else e = (a[c] - j < b[c]) ? b[c] : a[c] - j;
        check("fade_duty", hi[c], e);
      end
    end
    check("fade_idx", int'(step_idx), 1);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    tick_in = 1'b0;
    wr_en   = 1'b0;
    mode    = 2'b01;
    len     = '0;
    wr_addr = '0;
    wr_data = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_led", int'(led), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_idx", int'(step_idx), 0);
    end
    rst = 1'b0;
    #1;
    check("rel_busy", int'(busy), 0);
    @(negedge clk);
    en = 1'b0;

    wr(0, 1, 15, 8, 0);
    mode = 2'b01;
    len  = 2'd0;
    restart();
    check("busy_run", int'(busy), 1);
    check_entry("pwm_dir", 0);

    repeat (3) begin
      wr(0, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 15)));
      restart();
      check_entry("pwm_rnd", 0);
    end

    wr(0, 1, 1, 2, 3);
    wr(1, 2, 4, 5, 6);
    wr(2, 1, 7, 8, 9);
    wr(3, 3, 10, 11, 12);
    len = 2'd2;
    restart();
    run_steps(10);

    repeat (2) begin
      for (int a = 0; a < DEPTH; a++) begin
        wr(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      len = AW'($urandom_range(0, 3));
      restart();
      run_steps(12);
    end

    run_fade(0, 0, 0, 4, 0, 0);
    run_fade(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    run_fade(15, 0, 7, 2, 9, 7);

    mode = 2'b00;
    len  = 2'd0;
    wr(0, 1, 5, 3, 9);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    @(negedge clk);
    check("hold_load_busy", int'(busy), 1);
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = {4'd1, 4'd9, 4'd3, 4'd12};
    @(negedge clk);
    wr_en = 1'b0;
    cyc(1);
    check_entry("hold_old", 0);
    tbl_duty[0][0] = 12;
    tick();
    check("hold_idx", int'(step_idx), 0);
    check_entry("hold_new", 0);

    mode = 2'b01;
    len  = 2'd3;
    for (int a = 0; a < DEPTH; a++) begin
      wr(a, 1, int'($urandom_range(1, 15)), int'($urandom_range(1, 15)),
         int'($urandom_range(1, 15)));
    end
    restart();
    tick();
    tick();
    check("en_idx2", int'(step_idx), 2);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_busy", int'(busy), 0);
    @(negedge clk);
    check("en_led", int'(led), 0);
    check("en_idx0", int'(step_idx), 0);
    en = 1'b1;
    cyc(3);
    check("reen_idx", int'(step_idx), 0);
    check("reen_busy", int'(busy), 1);
    check_entry("reen_duty", 0);

    @(negedge clk);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = {4'd1, 4'd0, 4'd0, 4'd0};
    tick_in = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    wr_en   = 1'b0;
    tick_in = 1'b0;
    #1;
    check("rst_ovr_busy", int'(busy), 0);
    check("rst_ovr_idx", int'(step_idx), 0);
    cyc(3);
    check_entry("rst_ovr_tbl", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
